// File: rtl/v_red_fold_seq_if.sv
// Beat-in / result-out stream bundle for the sequential vector reduction unit.
interface v_red_fold_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/v_red_fold_seq.sv
// Lane-parallel vector reduction (sum/min/max): accumulates packed beats per lane,
// then folds the lanes pairwise down to one scalar element.
module v_red_fold_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int OPSEL_WIDTH = 2,
  parameter int SEW_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  s_init,
  input  logic [SEW_WIDTH-1:0]   sew,
  input  logic [OPSEL_WIDTH-1:0] opSel,
  input  logic                   sgn,
  input  logic                   flush,
  v_red_fold_seq_if.slave        bus,
  output logic                   busy
);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef int unsigned uint_t;
  typedef enum logic [1:0] {IDLE, ACCUM, FOLD, DONE} state_t;

  localparam uint_t MAX_SEW = uint_t'($clog2(DATA_WIDTH / 8));

  state_t      state, state_nxt;
  logic [1:0]  cfg_sew, cfg_op;
  logic        cfg_sgn;
  logic [3:0]  act;
  word_t       acc, out_q;
  word_t       accum_res, fold_res, init_res;
  logic [1:0]  start_sew;
  uint_t       ew, half_lanes;

  function automatic logic [1:0] clamp_sew(input logic [SEW_WIDTH-1:0] s);
    if (uint_t'(s) > MAX_SEW) return 2'(MAX_SEW);
    return 2'(s);
  endfunction

  function automatic uint_t ew_of(input logic [1:0] s);
    return uint_t'(8) << s;
  endfunction

  function automatic word_t low_mask(input uint_t bits);
    if (bits >= uint_t'(DATA_WIDTH)) return '1;
    return (word_t'(1) << bits) - word_t'(1);
  endfunction

  // Signed compare is done as unsigned compare with the element sign bits flipped.
  function automatic word_t elem_op(input word_t x, input word_t y, input uint_t w,
                                    input logic [1:0] op, input logic sg);
    word_t mask, msb, xc, yc;
    logic  lt;
    mask = low_mask(w);
    msb  = word_t'(1) << (w - 1);
    xc   = sg ? (x ^ msb) : x;
    yc   = sg ? (y ^ msb) : y;
    lt   = xc < yc;
    if (!op[1]) return (x + y) & mask;
    if (!op[0]) return lt ? x : y;
    return lt ? y : x;
  endfunction

  function automatic word_t vec_op(input word_t a, input word_t b, input uint_t w,
                                   input uint_t lanes, input logic [1:0] op, input logic sg);
    word_t res, mask;
    res  = '0;
    mask = low_mask(w);
    for (int unsigned i = 0; i < uint_t'(DATA_WIDTH / 8); i++) begin
      if (i < lanes)
        res |= elem_op((a >> (i * w)) & mask, (b >> (i * w)) & mask, w, op, sg) << (i * w);
    end
    return res;
  endfunction

  function automatic word_t init_vec(input word_t s, input uint_t w, input uint_t lanes,
                                     input logic [1:0] op, input logic sg);
    word_t res, mask, msb, ident;
    mask = low_mask(w);
    msb  = word_t'(1) << (w - 1);
    if (!op[1])      ident = '0;
    else if (!op[0]) ident = sg ? (mask ^ msb) : mask;
    else             ident = sg ? msb : '0;
    res = s & mask;
    for (int unsigned i = 1; i < uint_t'(DATA_WIDTH / 8); i++) begin
      if (i < lanes) res |= ident << (i * w);
    end
    return res;
  endfunction

  always_comb begin
    start_sew  = clamp_sew(sew);
    ew         = ew_of(cfg_sew);
    half_lanes = uint_t'(act[3:1]);
    init_res   = init_vec(s_init, ew_of(start_sew), uint_t'(DATA_WIDTH) / ew_of(start_sew),
                          opSel[1:0], sgn);
    accum_res  = vec_op(acc, bus.in_data, ew, uint_t'(act), cfg_op, cfg_sgn);
    fold_res   = vec_op(acc & low_mask(half_lanes * ew),
                        (acc >> (half_lanes * ew)) & low_mask(half_lanes * ew),
                        ew, half_lanes, cfg_op, cfg_sgn);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = ACCUM;
      ACCUM: if (bus.in_valid && bus.in_last) state_nxt = (act == 4'd1) ? DONE : FOLD;
      FOLD:  if (act == 4'd2) state_nxt = DONE;
      DONE:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_sew <= '0;
      cfg_op  <= '0;
      cfg_sgn <= 1'b0;
      act     <= '0;
      acc     <= '0;
      out_q   <= '0;
    end else if (flush) begin
      out_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          cfg_sew <= start_sew;
          cfg_op  <= opSel[1:0];
          cfg_sgn <= sgn;
          act     <= 4'(uint_t'(DATA_WIDTH) / ew_of(start_sew));
          acc     <= init_res;
        end
        ACCUM: if (bus.in_valid) begin
          acc <= accum_res;
          if (bus.in_last && act == 4'd1) out_q <= accum_res;
        end
        FOLD: begin
          acc <= fold_res;
          act <= act >> 1;
          if (act == 4'd2) out_q <= fold_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_q;
  assign busy          = (state != IDLE);

endmodule

// File: doc/v_red_fold_seq.md
V_RED_FOLD_SEQ -- requirements
Module: v_red_fold_seq

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_WIDTH, 32, packed vector word width (32 or 64)
  OPSEL_WIDTH, 2, opSel width
  SEW_WIDTH, 2, sew width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock
  rst  in  1  asynchronous, active-high reset
  start  in  1  pulse; latches cfg and s_init, begins a reduction
  s_init  in  DATA_WIDTH  scalar seed (element in low SEW bits)
  sew  in  SEW_WIDTH  0=8b, 1=16b, 2=32b, 3=64b elements
  opSel  in  OPSEL_WIDTH  00 sum, 01 sum (reserved), 10 min, 11 max
  sgn  in  1  1 = signed min/max compare
  flush  in  1  synchronous abort to IDLE
  in_valid  in  1  source beat valid
  in_data  in  DATA_WIDTH  packed element beat
  in_last  in  1  final beat of the vector
  in_ready  out  1  beat accept
  out_valid  out  1  result valid
  out_data  out  DATA_WIDTH  result, zero-extended above SEW
  out_ready  in  1  consumer accept
  busy  out  1  state != IDLE
REQ-003 Clock port SHALL be clk and reset port SHALL be rst; reset is asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, ACCUM, FOLD, DONE; all outputs SHALL be registered or derived from the state only.
REQ-005 Lane count L SHALL be DATA_WIDTH/(8<<sew); sew encoding wider than DATA_WIDTH SHALL be treated as SEW=DATA_WIDTH (L=1).
REQ-006 IDLE: in_ready=0, out_valid=0; start SHALL latch sew/opSel/sgn, load acc lane0=s_init element and lanes 1..L-1 with identity (sum 0; min all-ones unsigned/max-positive signed; max 0 unsigned/min-negative signed), then move to ACCUM.
REQ-007 ACCUM: in_ready=1; on in_valid&in_ready each lane SHALL update acc[i]=op(acc[i], in_data lane i) in one cycle.
REQ-008 Accepting a beat with in_last=1 SHALL move to FOLD if L>1, else directly to DONE.
REQ-009 FOLD: each cycle SHALL combine the low half of the active width with the high half lane-wise (op), halving the active width; after log2(L) cycles state SHALL be DONE.
REQ-010 Latency: out_valid SHALL rise log2(L)+1 clock edges after the edge accepting the last beat (1 for L=1, 3 for L=4).
REQ-011 Sum SHALL wrap modulo 2^SEW; min/max SHALL compare signed when sgn=1, unsigned otherwise.
REQ-012 DONE: out_valid=1, out_data stable; out_valid&out_ready SHALL return to IDLE next edge.
REQ-013 start SHALL be ignored in any state other than IDLE; cfg inputs SHALL be ignored except at accepted start.
REQ-014 flush SHALL return to IDLE on the next edge from any state, dropping any result; flush has priority over start and in_last.
REQ-015 in_valid while not in ACCUM SHALL be ignored (in_ready=0).

Reset
REQ-016 rst=1 SHALL asynchronously force IDLE, acc=0, out_data=0, out_valid=0, in_ready=0, busy=0, regardless of clk.
REQ-017 Reset asserted mid-ACCUM or mid-FOLD SHALL discard the operation; no out_valid follows deassertion.

Verification
REQ-018 sum, sew=0, s_init=0x05, beats 0x01020304, 0x10101010(last) -> out_data=0x0000004F, out_valid 3 edges after last accept.
REQ-019 min, sgn=1, sew=1, s_init=0x0003, beat 0xFFFE0007(last) -> out_data=0x0000FFFE after 2 edges.
REQ-020 max, sgn=0, sew=2, s_init=0x10, beats 0x80000000, 0x00000001(last) -> out_data=0x80000000, out_valid 1 edge after last.
REQ-021 sum wrap, sew=0, s_init=0xFF, beat 0x00000001(last) -> out_data=0x00000000.
REQ-022 out_ready low 3 cycles in DONE with start pulsed -> out_data/out_valid held, start ignored; flush mid-ACCUM -> IDLE, no out_valid.
REQ-023 rst pulsed asynchronously (between edges) during FOLD -> outputs 0 immediately, busy=0, no result after release.
